// File: rtl/seq_aru.sv
// Iterative W x W signed/unsigned multiplier with optional restoring divider.
// Define SEQ_ARU_DIV_EN to build the divider; without it DIVU/DIVS return err in one cycle.
module seq_aru #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         Z,
  output logic         N,
  output logic         err
);
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;

  logic [2*W-1:0] p, p_nxt, prod;
  logic [W-1:0]   d_q, a_mag, b_mag;
  logic [CW-1:0]  cnt;
  logic           neg_q, accept, fast, last;
  logic [W:0]     sum;

  assign accept = start && (state != CALC);
  assign last   = (state == CALC) && (cnt == CW'(W-1));
  assign a_mag  = (op[0] && in0[W-1]) ? -in0 : in0;
  assign b_mag  = (op[0] && in1[W-1]) ? -in1 : in1;
  assign busy   = (state == CALC);
  assign done   = (state == DONE);

`ifdef SEQ_ARU_DIV_EN
  logic         is_div, neg_r;
  logic [W:0]   r_sh, diff;
  logic [W-1:0] q_f, r_f;
  assign fast = op[1] && (in1 == '0);
`else
  assign fast = op[1];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = fast ? DONE : CALC;
      CALC:    if (last) state_nxt = DONE;
      DONE:    state_nxt = accept ? (fast ? DONE : CALC) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration: shift-add for multiply, restoring step for divide.
  always_comb begin
    sum   = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, d_q} : '0);
    p_nxt = {sum, p[W-1:1]};
`ifdef SEQ_ARU_DIV_EN
    r_sh = {p[2*W-1:W], p[W-1]};
    diff = r_sh - {1'b0, d_q};
    if (is_div)
      p_nxt = diff[W] ? {r_sh[W-1:0], p[W-2:0], 1'b0} : {diff[W-1:0], p[W-2:0], 1'b1};
    q_f = neg_q ? -p_nxt[W-1:0] : p_nxt[W-1:0];
    r_f = neg_r ? -p_nxt[2*W-1:W] : p_nxt[2*W-1:W];
`endif
    prod = neg_q ? -p_nxt : p_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p <= '0; d_q <= '0; cnt <= '0; neg_q <= 1'b0;
      hi <= '0; lo <= '0; Z <= 1'b0; N <= 1'b0; err <= 1'b0;
`ifdef SEQ_ARU_DIV_EN
      is_div <= 1'b0; neg_r <= 1'b0;
`endif
    end else if (accept) begin
      cnt   <= '0;
      neg_q <= op[0] && (in0[W-1] ^ in1[W-1]);
      d_q   <= op[1] ? b_mag : a_mag;
      p     <= {{W{1'b0}}, op[1] ? a_mag : b_mag};
`ifdef SEQ_ARU_DIV_EN
      is_div <= op[1];
      neg_r  <= op[0] && in0[W-1];
      if (fast) begin
        hi <= in0; lo <= '1; Z <= 1'b0; N <= 1'b1; err <= 1'b1;
      end
`else
      if (fast) begin
        hi <= '0; lo <= '0; Z <= 1'b0; N <= 1'b0; err <= 1'b1;
      end
`endif
    end else if (state == CALC) begin
      p   <= p_nxt;
      cnt <= cnt + CW'(1);
      if (last) begin
        err <= 1'b0;
`ifdef SEQ_ARU_DIV_EN
        if (is_div) begin
          hi <= r_f; lo <= q_f; Z <= (q_f == '0); N <= q_f[W-1];
        end else begin
          hi <= prod[2*W-1:W]; lo <= prod[W-1:0]; Z <= (prod == '0); N <= prod[2*W-1];
        end
`else
        hi <= prod[2*W-1:W]; lo <= prod[W-1:0]; Z <= (prod == '0); N <= prod[2*W-1];
`endif
      end
    end
  end
endmodule

// File: tb/tb_seq_aru.sv
// Directed bench for seq_aru (W=16): multiply, divide / divide-disabled, handshake and reset.
module tb_seq_aru;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] in0 = '0, in1 = '0;
  logic        busy, done, Z, N, err;
  logic [15:0] hi, lo;
  int          compared = 0, mismatched = 0;
  int          lat;
  bit          sb;

  seq_aru #(.W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .in0(in0), .in1(in1),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .Z(Z), .N(N), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [15:0] h, input logic [15:0] l,
                         input logic z, input logic n, input logic e);
    chk({tag, ".hi"}, {16'h0, hi}, {16'h0, h});
    chk({tag, ".lo"}, {16'h0, lo}, {16'h0, l});
    chk({tag, ".ZNerr"}, {29'h0, Z, N, err}, {29'h0, z, n, e});
  endtask

  // Drive a request for one edge; returns at the falling edge after acceptance.
  task automatic go(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b, input bit now);
    if (!now) @(negedge clk);
    start = 1'b1; op = o; in0 = a; in1 = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts cycles since acceptance until done; optionally pulses a stray start at pulse_at.
  task automatic wait_done(input int pulse_at, output int l, output bit saw_busy);
    l = 1; saw_busy = 1'b0;
    while (!done && l < 60) begin
      if (busy) saw_busy = 1'b1;
      if (l == pulse_at) begin
        start = 1'b1; op = 2'b00; in0 = 16'h0002; in1 = 16'h0003;
      end else start = 1'b0;
      @(negedge clk);
      l++;
    end
    start = 1'b0;
    chk("done_seen", {31'h0, done}, 32'h1);
    chk("busy_done_excl", {31'h0, busy & done}, 32'h0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst.ctl", {30'h0, busy, done}, 32'h0);
    chk_res("rst", 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    go(2'b00, 16'hFFFF, 16'hFFFF, 1'b0);
    wait_done(0, lat, sb);
    chk("mulu.lat", lat, 17);
    chk("mulu.busy", {31'h0, sb}, 32'h1);
    chk_res("mulu", 16'hFFFE, 16'h0001, 1'b0, 1'b1, 1'b0);

    go(2'b01, 16'hFFFD, 16'h0005, 1'b0);
    wait_done(0, lat, sb);
    chk_res("muls_neg", 16'hFFFF, 16'hFFF1, 1'b0, 1'b1, 1'b0);

    go(2'b01, 16'h0000, 16'h1234, 1'b0);
    wait_done(0, lat, sb);
    chk_res("muls_zero", 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);

`ifdef SEQ_ARU_DIV_EN
    go(2'b11, 16'hFFF9, 16'h0002, 1'b0);
    wait_done(0, lat, sb);
    chk("divs.lat", lat, 17);
    chk_res("divs_neg", 16'hFFFF, 16'hFFFD, 1'b0, 1'b1, 1'b0);

    go(2'b11, 16'h8000, 16'hFFFF, 1'b0);
    wait_done(0, lat, sb);
    chk_res("divs_ovf", 16'h0000, 16'h8000, 1'b0, 1'b1, 1'b0);

    go(2'b10, 16'd100, 16'd7, 1'b0);
    wait_done(0, lat, sb);
    chk_res("divu", 16'h0002, 16'h000E, 1'b0, 1'b0, 1'b0);

    go(2'b10, 16'd100, 16'd0, 1'b0);
    wait_done(0, lat, sb);
    chk("div0.lat", lat, 1);
    chk("div0.busy", {31'h0, sb}, 32'h0);
    chk_res("div0", 16'h0064, 16'hFFFF, 1'b0, 1'b1, 1'b1);
`else
    go(2'b10, 16'd100, 16'd5, 1'b0);
    wait_done(0, lat, sb);
    chk("nodiv.lat", lat, 1);
    chk("nodiv.busy", {31'h0, sb}, 32'h0);
    chk_res("nodiv_u", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);

    go(2'b11, 16'hFFF9, 16'h0002, 1'b0);
    wait_done(0, lat, sb);
    chk("nodiv_s.lat", lat, 1);
    chk_res("nodiv_s", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
`endif

    // Stray start in CALC cycle 5 (also changes operands) must not disturb the op.
    go(2'b00, 16'h1234, 16'h0010, 1'b0);
    wait_done(5, lat, sb);
    chk("ign.lat", lat, 17);
    chk_res("ign", 16'h0001, 16'h2340, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("ign.idle", {30'h0, busy, done}, 32'h0);

    // Back-to-back: issue in the DONE cycle of the previous op.
    go(2'b00, 16'h0003, 16'h0004, 1'b0);
    wait_done(0, lat, sb);
    chk_res("b2b_first", 16'h0000, 16'h000C, 1'b0, 1'b0, 1'b0);
    go(2'b00, 16'h00FF, 16'h0101, 1'b1);
    chk("b2b.busy", {31'h0, busy}, 32'h1);
    chk("b2b.hold_lo", {16'h0, lo}, 32'h0000_000C);
    wait_done(0, lat, sb);
    chk("b2b.lat", lat, 17);
    chk_res("b2b_second", 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0);

    // Reset in CALC cycle 8 clears everything at once.
    go(2'b00, 16'hFFFF, 16'hFFFF, 1'b0);
    repeat (7) @(negedge clk);
    chk("mid.busy_pre", {31'h0, busy}, 32'h1);
    rst = 1'b0;
    #1;
    chk("mid_rst.ctl", {30'h0, busy, done}, 32'h0);
    chk_res("mid_rst", 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    go(2'b01, 16'hFFFD, 16'h0005, 1'b0);
    wait_done(0, lat, sb);
    chk("post_rst.lat", lat, 17);
    chk_res("post_rst", 16'hFFFF, 16'hFFF1, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
